// File: rtl/jac_pkg.sv
// Shared definitions for the JAC core: default widths, opcode map and sequencer state encoding.
// The decoder imports this package too, so opcode values must stay in sync with it.
package jac_pkg;

   localparam int DefPcWidth          = 8;
   localparam int DefProgramDataWidth = 16;
   localparam int DefNumOpCodeBits    = 5;
   localparam int DefNumStatusBits    = 3;

   localparam logic [4:0] Op_Nop   = 5'h00;
   localparam logic [4:0] Op_Add   = 5'h01;
   localparam logic [4:0] Op_Sub   = 5'h02;
   localparam logic [4:0] Op_And   = 5'h03;
   localparam logic [4:0] Op_Or    = 5'h04;
   localparam logic [4:0] Op_Xor   = 5'h05;
   localparam logic [4:0] Op_Inc   = 5'h06;
   localparam logic [4:0] Op_Dec   = 5'h07;
   localparam logic [4:0] Op_Cmp   = 5'h08;
   localparam logic [4:0] Op_Val   = 5'h09;
   localparam logic [4:0] Op_Goto  = 5'h10;
   localparam logic [4:0] Op_Bz    = 5'h11;
   localparam logic [4:0] Op_Bnz   = 5'h12;
   localparam logic [4:0] Op_Ld    = 5'h13;
   localparam logic [4:0] Op_St    = 5'h14;
   localparam logic [4:0] Op_Mov   = 5'h15;

   // Two holes in the opcode space; everything there executes as a flagged NOP.
   localparam logic [4:0] Op_Rsv0Lo = 5'h0A;
   localparam logic [4:0] Op_Rsv0Hi = 5'h0F;
   localparam logic [4:0] Op_Rsv1Lo = 5'h16;
   localparam logic [4:0] Op_Rsv1Hi = 5'h1F;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StLoad  = 2'd2,
      StExec  = 2'd3
   } seq_state_e;

   function automatic logic is_alu_op(input int unsigned op);
      return (op >= 32'(Op_Add)) && (op <= 32'(Op_Cmp));
   endfunction

   function automatic logic is_reserved_op(input int unsigned op);
      return ((op >= 32'(Op_Rsv0Lo)) && (op <= 32'(Op_Rsv0Hi))) ||
             ((op >= 32'(Op_Rsv1Lo)) && (op <= 32'(Op_Rsv1Hi)));
   endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous load or increment, asynchronous clear; wraps modulo 2^WIDTH.
module pc_counter
   import jac_pkg::*;
#(
   parameter int WIDTH = DefPcWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             inc,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (inc) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/load/execute sequencer: one instruction every three cycles, continuous (run) or single-step.
// fsm_state mirrors the state register for observation.
module instr_sequencer
   import jac_pkg::*;
#(
   parameter int PC_WIDTH          = DefPcWidth,
   parameter int PROGRAM_DataWidth = DefProgramDataWidth,
   parameter int NumOpCodeBits     = DefNumOpCodeBits,
   parameter int NumStatusBits     = DefNumStatusBits
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         run,
   input  logic                         step,
   output logic [PC_WIDTH-1:0]          prog_addr,
   output logic                         prog_rd_en,
   input  logic [PROGRAM_DataWidth-1:0] prog_data,
   output logic [PROGRAM_DataWidth-1:0] instruction,
   input  logic [NumOpCodeBits-1:0]     dec_opcode,
   input  logic                         dec_wr_en,
   input  logic                         dec_cnt_wr_en,
   input  logic [PC_WIDTH-1:0]          dec_literal_adr,
   input  logic [NumStatusBits-1:0]     alu_status,
   output logic [NumStatusBits-1:0]     status,
   output logic                         reg_wr_en,
   output logic                         busy,
   output logic                         instr_done,
   output logic                         illegal,
   output logic [1:0]                   fsm_state
);

   seq_state_e                   state_q, state_d;
   logic                         single_q, single_d;
   logic [PROGRAM_DataWidth-1:0] ir_q;
   logic [NumStatusBits-1:0]     status_q;
   logic [PC_WIDTH-1:0]          pc;
   logic                         in_exec;
   logic                         op_reserved;
   logic                         op_alu;
   logic                         pc_load;
   logic                         pc_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         single_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         single_q <= single_d;
      end
   end

   // run has priority over step in IDLE; step is only looked at in IDLE, so a pulse while busy is dropped.
   always_comb begin
      state_d  = state_q;
      single_d = single_q;
      case (state_q)
         StIdle: begin
            if (run) begin
               state_d  = StFetch;
               single_d = 1'b0;
            end else if (step) begin
               state_d  = StFetch;
               single_d = 1'b1;
            end
         end
         StFetch: state_d = StLoad;
         StLoad:  state_d = StExec;
         StExec: begin
            state_d  = (run && !single_q) ? StFetch : StIdle;
            single_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_exec     = (state_q == StExec);
   assign op_reserved = is_reserved_op(32'(dec_opcode));
   assign op_alu      = is_alu_op(32'(dec_opcode));
   assign pc_load     = in_exec && dec_cnt_wr_en && !op_reserved;
   assign pc_inc      = in_exec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q <= '0;
      end else if (state_q == StLoad) begin
         ir_q <= prog_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= '0;
      end else if (in_exec && op_alu) begin
         status_q <= alu_status;
      end
   end

   pc_counter #(
      .WIDTH(PC_WIDTH)
   ) u_pc (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (pc_load),
      .inc       (pc_inc),
      .load_value(dec_literal_adr),
      .count     (pc)
   );

   assign prog_addr   = pc;
   assign prog_rd_en  = (state_q == StFetch);
   assign instruction = ir_q;
   assign status      = status_q;
   assign reg_wr_en   = in_exec && dec_wr_en && !op_reserved;
   assign busy        = (state_q != StIdle);
   assign instr_done  = in_exec;
   assign illegal     = in_exec && op_reserved;
   assign fsm_state   = state_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, program-counter and program-address width.
REQ-002 SHALL have parameter PROGRAM_DataWidth, default 16, instruction width.
REQ-003 SHALL have parameter NumOpCodeBits, default 5, opcode width.
REQ-004 SHALL have parameter NumStatusBits, default 3, ALU status flag count.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1, the single clock, all state updates on its rising edge.
REQ-006 rst_n input 1: asynchronous active-low reset.
REQ-007 run input 1: level; 1 means execute continuously.
REQ-008 step input 1: one-cycle pulse; executes exactly one instruction while run=0.
REQ-009 prog_addr output PC_WIDTH: program memory address, always equal to PC.
REQ-010 prog_rd_en output 1: program memory read strobe.
REQ-011 prog_data input PROGRAM_DataWidth: memory read data, valid on the cycle after prog_rd_en.
REQ-012 instruction output PROGRAM_DataWidth: instruction register (IR), feeds the decoder.
REQ-013 dec_opcode input NumOpCodeBits, dec_wr_en input 1, dec_cnt_wr_en input 1, dec_literal_adr input PC_WIDTH: decoder outputs for the current IR.
REQ-014 alu_status input NumStatusBits: combinational ALU flags.
REQ-015 status output NumStatusBits: latched flags, feed the decoder status input.
REQ-016 reg_wr_en output 1: gated register-file write enable.
REQ-017 busy output 1; instr_done output 1, one-cycle pulse; illegal output 1, one-cycle pulse.

Function
REQ-018 FSM SHALL have the states IDLE, FETCH, LOAD and EXEC.
REQ-019 IDLE -> FETCH when run=1, or when step=1 (step latched as single-step).
REQ-020 FETCH: prog_rd_en=1 for one cycle, then -> LOAD.
REQ-021 LOAD: IR <= prog_data, then -> EXEC.
REQ-022 EXEC: one cycle; reg_wr_en = dec_wr_en; instr_done=1.
REQ-023 EXEC: PC <= dec_literal_adr if dec_cnt_wr_en=1, else PC+1 modulo 2^PC_WIDTH (0xFF wraps to 0x00).
REQ-024 EXEC: if dec_opcode in 0_0001..0_1000 (ALU ops), status <= alu_status; all other opcodes leave status unchanged.
REQ-025 EXEC: reserved opcodes (0_1010..0_1111, 1_0110..1_1111) SHALL act as NOP (reg_wr_en=0, PC+1) and pulse illegal=1.
REQ-026 After EXEC: -> FETCH if run=1 and not in single-step, else -> IDLE; the single-step latch clears.
REQ-027 run falling mid-instruction SHALL complete the current instruction; the block stops in IDLE afterwards.
REQ-028 step while busy, or step with run=1, SHALL be ignored.
REQ-029 Outside EXEC: reg_wr_en=0, prog_rd_en=0 except in FETCH.
REQ-030 busy SHALL be 1 in FETCH, LOAD and EXEC.
REQ-031 Latency SHALL be exactly 3 cycles per instruction, with no pipelining.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, PC=0, IR=0, status=0, and every output 0.
REQ-033 Reset asserted mid-instruction SHALL abort it with no reg_wr_en pulse.

Structure
REQ-034 Opcode constants (Op_*), the state encoding and the width parameters SHALL reside in a shared package, jac_pkg, also used by the decoder.
REQ-035 The PC SHALL be one sub-module, pc_counter (load, increment, async clear); the FSM, IR and status register SHALL be local.

Verification
REQ-036 Reset then run=1 with mem[0]=ADD r1,r2 -> prog_addr 0x00, then 0x01; instruction=mem[0] in EXEC; one reg_wr_en pulse at cycle 3; instr_done every 3 cycles.
REQ-037 GOTO 0x3F at address 0x05 -> next prog_addr=0x3F; reg_wr_en=0.
REQ-038 SUB with alu_status=3'b001 in EXEC, then a VAL with alu_status=3'b110 -> status=3'b001 after SUB and stays 3'b001 after VAL.
REQ-039 run=0, step pulse at PC=0x10 -> exactly one instruction executes; PC=0x11; back in IDLE; a second step during busy is ignored.
REQ-040 Opcode 1_1000 at PC=0xFF -> illegal pulse, no write, PC=0x00.
REQ-041 rst_n low during LOAD -> all outputs 0 asynchronously; after release, fetch resumes from 0x00.
